// File: rtl/spi_minion_loopback_sched.sv
// Packet scheduler between the SPI minion adapter and the device port.
// Routes data to the device or loops it back, and buffers responses.
module spi_minion_loopback_sched #(
    parameter int pack_size = 32,
    parameter int nentries  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_en,
    input  logic [pack_size-1:0] push_msg,
    input  logic                 pull_en,
    output logic [pack_size-1:0] pull_msg,
    output logic [pack_size-3:0] dev_send_msg,
    output logic                 dev_send_val,
    input  logic                 dev_send_rdy,
    input  logic [pack_size-3:0] dev_recv_msg,
    input  logic                 dev_recv_val,
    output logic                 dev_recv_rdy,
    output logic                 loop_en,
    output logic                 overflow
);

    localparam int P  = pack_size - 2;
    localparam int AW = $clog2(nentries);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_q, state_d;
    logic [P-1:0]   send_msg_q, send_msg_d;
    logic           loop_q, loop_d;
    logic           ovf_q, ovf_d;
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic [P-1:0]   mem_q [nentries];

    logic           pkt_val, pkt_cfg;
    logic [P-1:0]   payload;
    logic           cfg_wr, data_pkt;
    logic           full, empty, credit;
    logic           push_enq, dev_enq, enq, deq;
    logic           send_acc, drop;
    logic [P-1:0]   enq_data;

    assign pkt_val  = push_msg[pack_size-1];
    assign pkt_cfg  = push_msg[pack_size-2];
    assign payload  = push_msg[P-1:0];
    assign cfg_wr   = push_en && pkt_val && pkt_cfg;
    assign data_pkt = push_en && pkt_val && !pkt_cfg;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign credit = (state_q == IDLE);

    // Loopback and device paths are exclusive through loop_q.
    assign push_enq = data_pkt && loop_q && !full;
    assign dev_recv_rdy = !loop_q && !full;
    assign dev_enq  = dev_recv_val && dev_recv_rdy;
    assign enq      = push_enq || dev_enq;
    assign enq_data = loop_q ? payload : dev_recv_msg;
    assign deq      = pull_en && !empty;

    assign send_acc = data_pkt && !loop_q && (state_q == IDLE);
    assign drop     = data_pkt && (loop_q ? full : (state_q == BUSY));

    assign pull_msg = empty ? {1'b0, credit, {P{1'b0}}}
                            : {1'b1, credit, mem_q[rd_ptr_q[AW-1:0]]};

    assign dev_send_val = (state_q == BUSY);
    assign dev_send_msg = send_msg_q;
    assign loop_en      = loop_q;
    assign overflow     = ovf_q;

    always_comb begin
        state_d    = state_q;
        send_msg_d = send_msg_q;
        unique case (state_q)
            IDLE: if (send_acc) begin
                state_d    = BUSY;
                send_msg_d = payload;
            end
            BUSY: if (dev_send_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        loop_d   = loop_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (cfg_wr) loop_d = payload[0];
        // A clear request beats a drop in the same cycle.
        if (cfg_wr && payload[1]) ovf_d = 1'b0;
        else if (drop)            ovf_d = 1'b1;
        if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
        if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            send_msg_q <= '0;
            loop_q     <= 1'b0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            send_msg_q <= send_msg_d;
            loop_q     <= loop_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q[AW-1:0]] <= enq_data;
    end

endmodule

// File: tb/tb_spi_minion_loopback_sched.sv
// Bench for spi_minion_loopback_sched: vector table with a
// scoreboard queue for packets returned to the master.
module tb_spi_minion_loopback_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_en, pull_en;
    logic [31:0] push_msg, pull_msg;
    logic [29:0] dev_send_msg, dev_recv_msg;
    logic        dev_send_val, dev_send_rdy;
    logic        dev_recv_val, dev_recv_rdy;
    logic        loop_en, overflow;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic        exp_busy;
    logic [29:0] sb_q [$];

    typedef struct {
        logic        push;
        logic [31:0] pmsg;
        logic        pull;
        logic        srdy;
        logic        rval;
        logic [29:0] rmsg;
        logic        sb;
        logic [29:0] sbv;
        logic        eloop;
        logic        eovf;
        logic        eval;
        logic [29:0] emsg;
        logic        erdy;
    } row_t;

    row_t rows [$];

    spi_minion_loopback_sched #(.pack_size(32), .nentries(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .push_en      (push_en),
        .push_msg     (push_msg),
        .pull_en      (pull_en),
        .pull_msg     (pull_msg),
        .dev_send_msg (dev_send_msg),
        .dev_send_val (dev_send_val),
        .dev_send_rdy (dev_send_rdy),
        .dev_recv_msg (dev_recv_msg),
        .dev_recv_val (dev_recv_val),
        .dev_recv_rdy (dev_recv_rdy),
        .loop_en      (loop_en),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic row_t mk(
        input logic push, input logic [31:0] pmsg, input logic pull,
        input logic srdy, input logic rval, input logic [29:0] rmsg,
        input logic sb, input logic [29:0] sbv,
        input logic eloop, input logic eovf, input logic eval,
        input logic [29:0] emsg, input logic erdy);
        row_t r;
        r.push = push; r.pmsg = pmsg; r.pull = pull; r.srdy = srdy;
        r.rval = rval; r.rmsg = rmsg; r.sb = sb; r.sbv = sbv;
        r.eloop = eloop; r.eovf = eovf; r.eval = eval;
        r.emsg = emsg; r.erdy = erdy;
        return r;
    endfunction

    task automatic run_row(input row_t r);
        logic [31:0] exp_pull;
        push_en      = r.push;
        push_msg     = r.pmsg;
        pull_en      = r.pull;
        dev_send_rdy = r.srdy;
        dev_recv_val = r.rval;
        dev_recv_msg = r.rmsg;
        #1;
        if (r.pull) begin
            if (sb_q.size() > 0) begin
                exp_pull = {1'b1, !exp_busy, sb_q[0]};
                void'(sb_q.pop_front());
            end else begin
                exp_pull = {1'b0, !exp_busy, 30'h0};
            end
            chk("pull_msg", pull_msg, exp_pull);
        end
        if (r.sb) sb_q.push_back(r.sbv);
        @(posedge clk);
        #1;
        push_en      = 1'b0;
        pull_en      = 1'b0;
        dev_recv_val = 1'b0;
        chk("loop_en", 32'(loop_en), 32'(r.eloop));
        chk("overflow", 32'(overflow), 32'(r.eovf));
        chk("dev_send_val", 32'(dev_send_val), 32'(r.eval));
        if (r.eval) chk("dev_send_msg", 32'(dev_send_msg), 32'(r.emsg));
        chk("dev_recv_rdy", 32'(dev_recv_rdy), 32'(r.erdy));
        exp_busy = r.eval;
    endtask

    initial begin
        // Loopback path: config, one echo, fill/overflow, drain, clear.
        rows.push_back(mk(0,32'h0,1,0,0,30'h0,0,30'h0, 0,0,0,30'h0,1));
        rows.push_back(mk(1,32'hC0000001,0,0,0,30'h0,0,30'h0, 1,0,0,30'h0,0));
        rows.push_back(mk(1,32'h80000ABC,0,0,0,30'h0,1,30'hABC, 1,0,0,30'h0,0));
        rows.push_back(mk(0,32'h0,1,0,0,30'h0,0,30'h0, 1,0,0,30'h0,0));
        rows.push_back(mk(1,32'h00000777,0,0,0,30'h0,0,30'h0, 1,0,0,30'h0,0));
        for (int i = 1; i <= 4; i++)
            rows.push_back(mk(1,32'h80000000 | 32'(i),0,0,0,30'h0,
                              1,30'(i), 1,0,0,30'h0,0));
        rows.push_back(mk(1,32'h80000005,0,0,0,30'h0,0,30'h0, 1,1,0,30'h0,0));
        for (int i = 0; i < 5; i++)
            rows.push_back(mk(0,32'h0,1,0,0,30'h0,0,30'h0, 1,1,0,30'h0,0));
        rows.push_back(mk(1,32'hC0000003,0,0,0,30'h0,0,30'h0, 1,0,0,30'h0,0));
        // Device path: busy, credit, drop while busy, release.
        rows.push_back(mk(1,32'hC0000000,0,0,0,30'h0,0,30'h0, 0,0,0,30'h0,1));
        rows.push_back(mk(1,32'h80000123,0,0,0,30'h0,0,30'h0, 0,0,1,30'h123,1));
        rows.push_back(mk(0,32'h0,1,0,0,30'h0,0,30'h0, 0,0,1,30'h123,1));
        rows.push_back(mk(1,32'h80000456,0,0,0,30'h0,0,30'h0, 0,1,1,30'h123,1));
        rows.push_back(mk(0,32'h0,0,1,0,30'h0,0,30'h0, 0,1,0,30'h0,1));
        rows.push_back(mk(0,32'h0,0,0,1,30'h55,1,30'h55, 0,1,0,30'h0,1));
        rows.push_back(mk(0,32'h0,1,0,0,30'h0,0,30'h0, 0,1,0,30'h0,1));
        rows.push_back(mk(1,32'hC0000002,0,0,0,30'h0,0,30'h0, 0,0,0,30'h0,1));
        // Device responses fill the FIFO; a fifth is refused.
        for (int i = 0; i < 4; i++)
            rows.push_back(mk(0,32'h0,0,0,1,30'h10 + 30'(i),1,30'h10 + 30'(i),
                              0,0,0,30'h0,(i < 3) ? 1'b1 : 1'b0));
        rows.push_back(mk(0,32'h0,0,0,1,30'h14,0,30'h0, 0,0,0,30'h0,0));
        for (int i = 0; i < 4; i++)
            rows.push_back(mk(0,32'h0,1,0,0,30'h0,0,30'h0, 0,0,0,30'h0,1));
        // Same-cycle push and pull in loopback.
        rows.push_back(mk(1,32'hC0000001,0,0,0,30'h0,0,30'h0, 1,0,0,30'h0,0));
        rows.push_back(mk(1,32'h80000AAA,0,0,0,30'h0,1,30'hAAA, 1,0,0,30'h0,0));
        rows.push_back(mk(1,32'h80000BBB,1,0,0,30'h0,1,30'hBBB, 1,0,0,30'h0,0));
        rows.push_back(mk(0,32'h0,1,0,0,30'h0,0,30'h0, 1,0,0,30'h0,0));
        // Busy with two queued responses, ahead of the reset check.
        rows.push_back(mk(1,32'hC0000000,0,0,0,30'h0,0,30'h0, 0,0,0,30'h0,1));
        rows.push_back(mk(1,32'h80000077,0,0,0,30'h0,0,30'h0, 0,0,1,30'h77,1));
        rows.push_back(mk(0,32'h0,0,0,1,30'h21,1,30'h21, 0,0,1,30'h77,1));
        rows.push_back(mk(0,32'h0,0,0,1,30'h22,1,30'h22, 0,0,1,30'h77,1));

        push_en = 0; push_msg = '0; pull_en = 0;
        dev_send_rdy = 0; dev_recv_val = 0; dev_recv_msg = '0;
        exp_busy = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst pull_msg", pull_msg, 32'h40000000);
        chk("rst loop_en", 32'(loop_en), 32'h0);
        chk("rst overflow", 32'(overflow), 32'h0);
        chk("rst dev_send_val", 32'(dev_send_val), 32'h0);
        chk("rst dev_send_msg", 32'(dev_send_msg), 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (rows[i]) run_row(rows[i]);

        chk("pre-rst pull_msg", pull_msg, 32'h80000021);
        #2;
        reset = 1'b1;
        #1;
        chk("async rst dev_send_val", 32'(dev_send_val), 32'h0);
        chk("async rst dev_send_msg", 32'(dev_send_msg), 32'h0);
        chk("async rst pull_msg", pull_msg, 32'h40000000);
        sb_q.delete();
        exp_busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_row(mk(0,32'h0,1,0,0,30'h0,0,30'h0, 0,0,0,30'h0,1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
